// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between the instruction-fetch requester and
// the data (load/store) requester. One access is in flight at a time; the
// winner's address/we/wdata are latched onto the mem_* outputs, held for the
// whole access, and completion is reported with a one-cycle ack. A watchdog
// aborts an access after TIMEOUT access cycles without mem_ready, reporting
// the ack together with err and returning zero read data.
//
// Handshake: a requester raises req with stable address/data and holds it
// until its ack pulse; the ack cycle ends the transaction and req must be
// low by the edge that ends the ack cycle, otherwise it is a new request.
// The memory side completes an access by asserting mem_ready for one cycle
// while mem_en is high; mem_ready at any other time is ignored.
//
// Build option: define ARB_RR_EN for round-robin arbitration between the two
// requesters; without it, data requests win ties against fetches.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   if_req/if_addr              fetch request and address
//   if_ack/if_rdata             fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata   data request (we=1 store, 0 load)
//   d_ack/d_rdata               data completion pulse and load data
//   err                         pulses with the ack of a timed-out access
//   mem_en/mem_we/mem_addr/mem_wdata   memory command (registered)
//   mem_rdata/mem_ready         memory read data and completion
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IF_ACC = 2'd1;
    localparam logic [1:0] S_D_ACC  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // The counter only has to reach TIMEOUT-1: the last waiting cycle is
    // recognised by comparison rather than by counting past it.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] wd_cnt;
    logic             grant_d;

`ifdef ARB_RR_EN
    // 1 = fetch was granted last, so data wins the next tie.
    logic last_fetch;

    assign grant_d = d_req && (!if_req || last_fetch);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_fetch <= 1'b1;
        end else if (state == S_IDLE && (if_req || d_req)) begin
            last_fetch <= !grant_d;
        end
    end
`else
    // Data wins ties so the instruction already in flight can finish.
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wd_cnt    <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (if_req || d_req) begin
                        mem_en <= 1'b1;
                        wd_cnt <= '0;
                        if (grant_d) begin
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                            state     <= S_D_ACC;
                        end else begin
                            mem_addr <= if_addr;
                            mem_we   <= 1'b0;
                            state    <= S_IF_ACC;
                        end
                    end
                end
                S_IF_ACC, S_D_ACC: begin
                    if (mem_ready) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= S_RESP;
                        if (state == S_IF_ACC) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            // Stores leave the last load result visible.
                            if (!mem_we) d_rdata <= mem_rdata;
                        end
                    end else if (wd_cnt == CNT_LAST) begin
                        // Watchdog abort: ack with err, zero read data.
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        err    <= 1'b1;
                        state  <= S_RESP;
                        if (state == S_IF_ACC) begin
                            if_ack   <= 1'b1;
                            if_rdata <= '0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= '0;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    // Requests are ignored here; the requester drops req now.
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
